uart_frame_engine: RTL
======================

Name: uart_frame_engine

Overview:
- Framed-packet layer between the byte-level UART core and the coprocessor logic, replacing fixed raw-byte frames.
- RX: assembles checksummed frames addressed to one of NUM_CH channels and delivers them as a one-cycle strobe.
- TX: serialises a response frame into the UART byte stream when triggered by an internal pulse or by the external valid pin (interconnect[2]).
- Drives a received-data valid level for interconnect[3].

Parameters:
- DBITS, 8, bits per UART byte.
- FRAME_BYTES, 18, payload bytes per frame (≥1).
- NUM_CH, 4, number of addressable channels (≥1, ≤ 2^DBITS).
- SOF, 8'hA5, start-of-frame byte.
- TIMEOUT_CYCLES, 1_033_400, max clk cycles between RX bytes (10 ms at 103.34 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  DBITS  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  DBITS  byte to UART transmitter.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready.
- frame_out  out  FRAME_BYTES*DBITS  last good payload; byte k at [DBITS*k+DBITS-1 : DBITS*k].
- frame_ch  out  $clog2(NUM_CH) (min 1)  channel of frame_out.
- frame_valid  out  1  one-cycle strobe on good frame.
- frame_err  out  1  one-cycle strobe on checksum, channel or timeout error.
- rx_avail  out  1  level; set on good frame, cleared by rx_ack (to interconnect[3]).
- rx_ack  in  1  clears rx_avail.
- ext_send  in  1  asynchronous pin (interconnect[2]); rising edge triggers TX.
- tx_send  in  1  synchronous one-cycle TX trigger.
- tx_ch  in  same as frame_ch  channel for TX frame.
- tx_payload  in  FRAME_BYTES*DBITS  TX payload; sampled on trigger.
- tx_busy  out  1  TX frame in progress.

Behaviour:
- Wire format: SOF, CH, payload byte 0 … byte FRAME_BYTES-1, CHK. CHK = XOR of CH and all payload bytes.
- Reset values: all outputs 0, both FSMs in IDLE, timeout counter 0, sync flops 0.
- RX FSM:
  - R_IDLE: wait for rx_valid with rx_data==SOF → R_CH; all other bytes ignored silently.
  - R_CH: latch CH, init running XOR → R_PAY.
  - R_PAY: shift bytes into the holding register at index cnt. After byte FRAME_BYTES-1 → R_CHK.
  - R_CHK: the frame is good if CHK matches and CH < NUM_CH. Good frame: copy holding register to frame_out and CH to frame_ch on the same edge; next cycle frame_valid=1 and rx_avail=1. Bad frame: frame_err=1, frame_out unchanged. Both cases → R_IDLE.
  - Latency: frame_valid rises the cycle after the CHK byte's rx_valid.
- Timeout: the counter runs in every state except R_IDLE and clears on each rx_valid. Reaching TIMEOUT_CYCLES → frame_err pulse, → R_IDLE.
- No SOF resync mid-frame: an SOF byte inside the payload is treated as data.
- rx_avail: set has priority over rx_ack when both occur in the same cycle.
- ext_send:
  - Two-flop synchroniser, then rising-edge detect; trigger = edge | tx_send.
  - Triggers while tx_busy=1 are dropped (no queueing).
- TX FSM:
  - T_IDLE: on trigger, latch tx_ch and tx_payload, tx_busy=1 → T_SOF.
  - T_SOF → T_CH → T_PAY (FRAME_BYTES bytes) → T_CHK → T_IDLE. Each state advances only on tx_valid && tx_ready.
  - tx_valid is asserted continuously in T_SOF..T_CHK; tx_data is stable while waiting.
  - tx_busy drops the cycle after the CHK byte is accepted. A new trigger in that same cycle is accepted.
  - The first byte is presented the cycle after the trigger.
- RX and TX are independent and operate fully concurrently.
- Reset mid-operation: both frames are abandoned and nothing is emitted.

Decomposition:
- Shared package uart_frame_pkg holds:
  - SOF default.
  - RX and TX state encodings.
  - CHK function (XOR reduce).
  - Channel-width helper.
- Natural sub-module: uart_frame_tx, containing the TX FSM, synchroniser and edge detect. RX stays in the top of the block.

Test Plan:
- Good frame: FRAME_BYTES=4, NUM_CH=4, bytes A5,02,11,22,33,44,CHK=02^11^22^33^44=0x46 → frame_valid 1 cycle, frame_ch=2, frame_out=32'h44332211, rx_avail=1 until rx_ack.
- Bad checksum: same frame with CHK=0x47 → frame_err pulse, no frame_valid, frame_out retains its previous value.
- Timeout: TIMEOUT_CYCLES=100; send A5,01,11 then idle 100 cycles → frame_err pulse; a following full good frame is then received correctly.
- Bad channel: CH=0x05 with correct CHK → frame_err, no frame_valid. Garbage 00,FF before SOF → ignored.
- TX with backpressure: tx_send with tx_ch=1, payload 32'hDDCCBBAA, tx_ready toggling every other cycle → byte sequence A5,01,AA,BB,CC,DD,CHK=0x01^AA^BB^CC^DD=0x01 with no duplicates or drops; second tx_send while busy → ignored.
- ext_send pin: held high for 50 cycles → exactly one frame sent; reset asserted mid-TX → tx_valid=0 and tx_busy=0 immediately.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framed-packet layer: SOF default, FSM
// encodings, checksum step and channel-width helper.
package uart_frame_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CH,
        R_PAY,
        R_CHK
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SOF,
        T_CH,
        T_PAY,
        T_CHK
    } tx_state_t;

    // One step of the XOR-reduce checksum; callers zero-extend and truncate.
    function automatic logic [31:0] chk_step(input logic [31:0] acc, input logic [31:0] b);
        return acc ^ b;
    endfunction

    // Width of an index into n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// TX side: ext_send synchroniser and edge detect, trigger capture and the
// byte serialiser that walks SOF, CH, payload, CHK with ready/valid handshake.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int              DBITS       = 8,
    parameter int              FRAME_BYTES = 18,
    parameter int              CHW         = 2,
    parameter logic [DBITS-1:0] SOF        = DBITS'(SOF_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ext_send,
    input  logic                         tx_send,
    input  logic [CHW-1:0]               tx_ch,
    input  logic [FRAME_BYTES*DBITS-1:0] tx_payload,
    input  logic                         tx_ready,
    output logic [DBITS-1:0]             tx_data,
    output logic                         tx_valid,
    output logic                         tx_busy
);

    localparam int CW = ch_width(FRAME_BYTES);

    tx_state_t                    state_reg, state_next;
    logic [2:0]                   sync_reg;
    logic                         trigger;
    logic [DBITS-1:0]             ch_reg;
    logic [DBITS-1:0]             chk_reg;
    logic [DBITS-1:0]             chk_calc;
    logic [FRAME_BYTES*DBITS-1:0] pay_reg;
    logic [CW-1:0]                cnt_reg;

    // sync_reg[1:0] resynchronise the pin, sync_reg[2] holds the previous level.
    assign trigger = (sync_reg[1] & ~sync_reg[2]) | tx_send;
    assign tx_busy = (state_reg != T_IDLE);

    always_comb begin
        chk_calc = DBITS'(tx_ch);
        for (int k = 0; k < FRAME_BYTES; k++) begin
            chk_calc = DBITS'(chk_step(32'(chk_calc), 32'(tx_payload[k*DBITS +: DBITS])));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= T_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_valid   = 1'b0;
        tx_data    = '0;
        case (state_reg)
            T_IDLE: begin
                if (trigger) state_next = T_SOF;
            end
            T_SOF: begin
                tx_valid = 1'b1;
                tx_data  = SOF;
                if (tx_ready) state_next = T_CH;
            end
            T_CH: begin
                tx_valid = 1'b1;
                tx_data  = ch_reg;
                if (tx_ready) state_next = T_PAY;
            end
            T_PAY: begin
                tx_valid = 1'b1;
                tx_data  = pay_reg[DBITS-1:0];
                if (tx_ready && cnt_reg == CW'(FRAME_BYTES - 1)) state_next = T_CHK;
            end
            T_CHK: begin
                tx_valid = 1'b1;
                tx_data  = chk_reg;
                if (tx_ready) state_next = T_IDLE;
            end
            default: state_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
            ch_reg   <= '0;
            chk_reg  <= '0;
            pay_reg  <= '0;
            cnt_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], ext_send};
            if (state_reg == T_IDLE && trigger) begin
                ch_reg  <= DBITS'(tx_ch);
                pay_reg <= tx_payload;
                chk_reg <= chk_calc;
                cnt_reg <= '0;
            end else if (state_reg == T_PAY && tx_ready) begin
                // Shift so the next payload byte is always at the bottom.
                pay_reg <= pay_reg >> DBITS;
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_frame_engine.sv
// Framed-packet layer: RX frame assembly with checksum/channel/timeout checks,
// plus the TX serialiser instance.
module uart_frame_engine
    import uart_frame_pkg::*;
#(
    parameter int               DBITS          = 8,
    parameter int               FRAME_BYTES    = 18,
    parameter int               NUM_CH         = 4,
    parameter logic [DBITS-1:0] SOF            = DBITS'(SOF_DEFAULT),
    parameter int               TIMEOUT_CYCLES = 1_033_400,
    localparam int              CHW            = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DBITS-1:0]             rx_data,
    input  logic                         rx_valid,
    output logic [DBITS-1:0]             tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [FRAME_BYTES*DBITS-1:0] frame_out,
    output logic [CHW-1:0]               frame_ch,
    output logic                         frame_valid,
    output logic                         frame_err,
    output logic                         rx_avail,
    input  logic                         rx_ack,
    input  logic                         ext_send,
    input  logic                         tx_send,
    input  logic [CHW-1:0]               tx_ch,
    input  logic [FRAME_BYTES*DBITS-1:0] tx_payload,
    output logic                         tx_busy
);

    localparam int             CW       = ch_width(FRAME_BYTES);
    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DBITS:0] NUM_CH_L = (DBITS + 1)'(NUM_CH);

    rx_state_t                    state_reg, state_next;
    logic [CW-1:0]                cnt_reg;
    logic [DBITS-1:0]             ch_reg;
    logic [DBITS-1:0]             xor_reg;
    logic [FRAME_BYTES*DBITS-1:0] hold_reg;
    logic [TW-1:0]                timer_reg;
    logic [FRAME_BYTES*DBITS-1:0] frame_out_reg;
    logic [CHW-1:0]               frame_ch_reg;
    logic                         frame_valid_reg;
    logic                         frame_err_reg;
    logic                         rx_avail_reg;
    logic                         timeout_hit;
    logic                         good_frame;
    logic                         bad_frame;

    assign frame_out   = frame_out_reg;
    assign frame_ch    = frame_ch_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;
    assign rx_avail    = rx_avail_reg;

    assign timeout_hit = (state_reg != R_IDLE) && !rx_valid &&
                         (timer_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= R_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (timeout_hit) begin
            state_next = R_IDLE;
            bad_frame  = 1'b1;
        end else if (rx_valid) begin
            case (state_reg)
                R_IDLE: if (rx_data == SOF) state_next = R_CH;
                R_CH:   state_next = R_PAY;
                R_PAY:  if (cnt_reg == CW'(FRAME_BYTES - 1)) state_next = R_CHK;
                R_CHK: begin
                    state_next = R_IDLE;
                    if (rx_data == xor_reg && {1'b0, ch_reg} < NUM_CH_L) good_frame = 1'b1;
                    else                                                 bad_frame  = 1'b1;
                end
                default: state_next = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg         <= '0;
            ch_reg          <= '0;
            xor_reg         <= '0;
            hold_reg        <= '0;
            timer_reg       <= '0;
            frame_out_reg   <= '0;
            frame_ch_reg    <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            rx_avail_reg    <= 1'b0;
        end else begin
            frame_valid_reg <= good_frame;
            frame_err_reg   <= bad_frame;

            // Idle never times out; any byte restarts the inter-byte window.
            if (state_reg == R_IDLE || rx_valid || timeout_hit) timer_reg <= '0;
            else                                                 timer_reg <= timer_reg + TW'(1);

            if (good_frame) begin
                frame_out_reg <= hold_reg;
                frame_ch_reg  <= ch_reg[CHW-1:0];
            end

            if (good_frame)  rx_avail_reg <= 1'b1;
            else if (rx_ack) rx_avail_reg <= 1'b0;

            if (rx_valid) begin
                case (state_reg)
                    R_CH: begin
                        ch_reg  <= rx_data;
                        xor_reg <= rx_data;
                        cnt_reg <= '0;
                    end
                    R_PAY: begin
                        for (int k = 0; k < FRAME_BYTES; k++) begin
                            if (cnt_reg == CW'(k)) hold_reg[k*DBITS +: DBITS] <= rx_data;
                        end
                        xor_reg <= DBITS'(chk_step(32'(xor_reg), 32'(rx_data)));
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_frame_tx #(
        .DBITS       (DBITS),
        .FRAME_BYTES (FRAME_BYTES),
        .CHW         (CHW),
        .SOF         (SOF)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .ext_send   (ext_send),
        .tx_send    (tx_send),
        .tx_ch      (tx_ch),
        .tx_payload (tx_payload),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_busy    (tx_busy)
    );

endmodule
